fp_mul_exception_stage: RTL

Downstream stage of the pipelined single-precision multiplier. It takes the raw product word from the multiplier, plus the two operands delay-aligned with that product. It overrides the raw word for IEEE-754 special cases (NaN, infinity, zero/denormal, exponent overflow/underflow) and attaches exception flags. Results go into a small synchronous FIFO, so the FSM-driven multiplier is decoupled from a backpressuring consumer through a valid/ready interface.

---
 rtl/fpu_mul_pkg.sv | 52 +++++
 rtl/fp_sync_fifo.sv | 41 ++++
 rtl/fp_mul_exception_stage.sv | 67 ++++++
 3 files changed

// File: rtl/fpu_mul_pkg.sv
// fpu_mul_pkg: constants, flag indices and special-case classifier for the single-precision multiplier.
package fpu_mul_pkg;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   localparam int BIAS = 127;
   localparam int FLG_INV = 4;
   localparam int FLG_INF = 3;
   localparam int FLG_ZERO = 2;
   localparam int FLG_OF = 1;
   localparam int FLG_UF = 0;

   // returns {result, flags}; denormal operands are treated as zero
   function automatic logic [36:0] classify_product(input logic [31:0] op_a, input logic [31:0] op_b,
                                                    input logic [31:0] raw);
      logic [7:0] ea, eb, pe;
      logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      logic signed [9:0] en;
      logic [31:0] r;
      logic [4:0] f;
      ea = op_a[30:23];
      eb = op_b[30:23];
      pe = raw[30:23];
      s = op_a[31] ^ op_b[31];
      nan_a = (ea == 8'hFF) && (op_a[22:0] != 23'h0);
      nan_b = (eb == 8'hFF) && (op_b[22:0] != 23'h0);
      inf_a = (ea == 8'hFF) && (op_a[22:0] == 23'h0);
      inf_b = (eb == 8'hFF) && (op_b[22:0] == 23'h0);
      zero_a = ea == 8'h00;
      zero_b = eb == 8'h00;
      en = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(BIAS);
      r = raw;
      f = '0;
      if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
         r = QNAN;
         f[FLG_INV] = 1'b1;
      end else if (inf_a || inf_b) begin
         r = {s, 8'hFF, 23'h0};
         f[FLG_INF] = 1'b1;
      end else if (zero_a || zero_b) begin
         r = {s, 31'h0};
         f[FLG_ZERO] = 1'b1;
      end else if (en >= 10'sd255 || (en == 10'sd254 && pe == 8'hFF)) begin
         r = {s, 8'hFF, 23'h0};
         f[FLG_OF] = 1'b1;
         f[FLG_INF] = 1'b1;
      end else if (en < 10'sd0 || (en == 10'sd0 && pe != 8'd1)) begin
         r = {s, 31'h0};
         f[FLG_UF] = 1'b1;
         f[FLG_ZERO] = 1'b1;
      end
      return {r, f};
   endfunction
endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module fp_sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;

   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign count = wr_ptr - rd_ptr;
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
         rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk_in)
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/fp_mul_exception_stage.sv
// fp_mul_exception_stage: IEEE-754 special-case override of the raw product, buffered in a valid/ready FIFO.
// Optional FPU_EXC_COUNT_EN adds saturating invalid/overflow/underflow push counters.
module fp_mul_exception_stage
   import fpu_mul_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int E_WIDTH = 8,
   parameter int M_WIDTH = 23,
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [D_WIDTH-1:0]       op_a,
   input  logic [D_WIDTH-1:0]       op_b,
   input  logic [D_WIDTH-1:0]       raw_product,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [D_WIDTH-1:0]       out_result,
   output logic [4:0]               out_flags,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef FPU_EXC_COUNT_EN
   ,
   output logic [15:0]              cnt_invalid,
   output logic [15:0]              cnt_overflow,
   output logic [15:0]              cnt_underflow
`endif
);
   logic [D_WIDTH+4:0] cls;
   logic full, empty;

   assign cls = classify_product({op_a[D_WIDTH-1], op_a[D_WIDTH-2 -: E_WIDTH], op_a[M_WIDTH-1:0]},
                                 {op_b[D_WIDTH-1], op_b[D_WIDTH-2 -: E_WIDTH], op_b[M_WIDTH-1:0]},
                                 raw_product);
   assign in_ready = ~full;
   assign out_valid = ~empty;

   fp_sync_fifo #(.WIDTH(D_WIDTH + 5), .DEPTH(DEPTH)) u_fifo (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .push    (in_valid),
      .wr_data (cls),
      .pop     (out_ready),
      .rd_data ({out_result, out_flags}),
      .full    (full),
      .empty   (empty),
      .count   (occupancy)
   );

`ifdef FPU_EXC_COUNT_EN
   logic push_ok;
   assign push_ok = in_valid & in_ready;

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         cnt_invalid <= '0;
         cnt_overflow <= '0;
         cnt_underflow <= '0;
      end else begin
         cnt_invalid <= cnt_invalid + {15'd0, push_ok & cls[FLG_INV] & ~&cnt_invalid};
         cnt_overflow <= cnt_overflow + {15'd0, push_ok & cls[FLG_OF] & ~&cnt_overflow};
         cnt_underflow <= cnt_underflow + {15'd0, push_ok & cls[FLG_UF] & ~&cnt_underflow};
      end
   end
`endif
endmodule
